// File: rtl/mul_arbiter_pkg.sv
// mul_arbiter_pkg: shared types and constants for the mul_arbiter slice.
//   DEFAULT_WIDTH : default operand width (product is twice as wide)
//   state_e       : sequencing FSM encoding (IDLE / MUL / DONE, 2 bits)
//   grant_t       : result of the round-robin decision (valid + winning id)
//   rr_grant()    : two-way round-robin selection against the last grant
package mul_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic vld;
    logic id;
  } grant_t;

  // A lone requester always wins; on a tie the one that did not win last time
  // is chosen, so lg=1 lets requester 0 take the first tie.
  function automatic grant_t rr_grant(input logic v0, input logic v1, input logic lg);
    grant_t g;
    g.vld = v0 | v1;
    if (v0 && v1) begin
      g.id = ~lg;
    end else begin
      g.id = v1;
    end
    return g;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Handshake bundles used by mul_arbiter.
//   mul_req_if : requester -> arbiter channel (valid, ready, a, b, sign)
//                master = requester side, slave = arbiter side
//   mul_out_if : arbiter -> consumer channel (valid, ready, prod, id)
//                master = arbiter side, slave = consumer side
interface mul_req_if #(parameter int N = mul_arbiter_pkg::DEFAULT_WIDTH);
  logic         valid;
  logic         ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sign;

  modport master (output valid, output a, output b, output sign, input ready);
  modport slave  (input valid, input a, input b, input sign, output ready);
endinterface

interface mul_out_if #(parameter int N = mul_arbiter_pkg::DEFAULT_WIDTH);
  logic           valid;
  logic           ready;
  logic [2*N-1:0] prod;
  logic           id;

  modport master (output valid, output prod, output id, input ready);
  modport slave  (input valid, input prod, input id, output ready);
endinterface

// File: rtl/mul_arbiter_multiplier.sv
// multiplier: shared combinational N x N multiplier.
//   a, b  : operands
//   sign  : 1 = operands are two's complement, full 2N-bit signed product
//           0 = unsigned operands and product
//   prod  : 2N-bit product
module multiplier #(
  parameter int N = mul_arbiter_pkg::DEFAULT_WIDTH
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           sign,
  output logic [2*N-1:0] prod
);

  logic [2*N-1:0] a_ext_s;
  logic [2*N-1:0] b_ext_s;

  // Extending to 2N bits first makes a plain modular multiply give the exact
  // product in both modes, including most-negative x most-negative.
  assign a_ext_s = sign ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
  assign b_ext_s = sign ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
  assign prod    = a_ext_s * b_ext_s;

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: two-requester round-robin front end for the shared multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   req0, req1 : requester channels (mul_req_if.slave)
//   out        : product channel tagged with requester id (mul_out_if.master)
//   busy       : high whenever an operation is in flight (state != IDLE)
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_req_if.slave  req0,
  mul_req_if.slave  req1,
  mul_out_if.master out,
  output logic      busy
);

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           sign_q, sign_d;
  logic           id_q, id_d;
  logic           lg_q, lg_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           out_id_q, out_id_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  grant_t         gnt_s;
  logic           window_s;
  logic           accept_s;
  logic [2*N-1:0] mul_prod_s;

  multiplier #(.N(N)) u_mul (
    .a    (a_q),
    .b    (b_q),
    .sign (sign_q),
    .prod (mul_prod_s)
  );

  // Grant and accept window; rst_n gates accept so ready is low during reset.
  always_comb begin
    gnt_s    = rr_grant(req0.valid, req1.valid, lg_q);
    window_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out.ready);
    accept_s = gnt_s.vld && window_s && rst_n;
  end

  assign req0.ready = accept_s && !gnt_s.id;
  assign req1.ready = accept_s &&  gnt_s.id;

  // Next-state and register-load logic for the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    id_d     = id_q;
    lg_d     = lg_q;
    prod_d   = prod_q;
    out_id_d = out_id_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        state_d  = ST_DONE;
        prod_d   = mul_prod_s;
        out_id_d = id_q;
      end
      ST_DONE: begin
        if (out.ready) begin
          // Accepting in the same cycle as the hand-off keeps the 2-cycle cadence.
          state_d = accept_s ? ST_MUL : ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      a_d    = gnt_s.id ? req1.a    : req0.a;
      b_d    = gnt_s.id ? req1.b    : req0.b;
      sign_d = gnt_s.id ? req1.sign : req0.sign;
      id_d   = gnt_s.id;
      lg_d   = gnt_s.id;
    end else begin
      a_d    = a_q;
      b_d    = b_q;
      sign_d = sign_q;
      id_d   = id_q;
      lg_d   = lg_q;
    end

    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and datapath registers; outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      sign_q      <= 1'b0;
      id_q        <= 1'b0;
      lg_q        <= 1'b1;
      prod_q      <= {(2*N){1'b0}};
      out_id_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      id_q        <= id_d;
      lg_q        <= lg_d;
      prod_q      <= prod_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out.valid = out_valid_q;
  assign out.prod  = prod_q;
  assign out.id    = out_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter (N=8): a timing/arbitration reference model
// predicts ready/valid/busy every cycle and pushes expected products; an
// output monitor pops and compares on each out handshake.
module tb_mul_arbiter;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
  } op_t;

  typedef struct {
    logic [15:0] prod;
    logic        id;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mul_req_if #(.N(8)) r0_if ();
  mul_req_if #(.N(8)) r1_if ();
  mul_out_if #(.N(8)) o_if ();

  mul_arbiter #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (r0_if),
    .req1  (r1_if),
    .out   (o_if),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  op_t  q0[$];
  op_t  q1[$];
  res_t sb[$];

  int checks   = 0;
  int failures = 0;

  bit acc0 = 1'b0;
  bit acc1 = 1'b0;
  bit have_op = 1'b0;
  bit lg_m = 1'b1;
  int op_cyc = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    int p;
    if (s) p = int'($signed(a)) * int'($signed(b));
    else   p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  function automatic logic [7:0] rnd8();
    logic [7:0] v;
    case ($urandom_range(0, 5))
      0: v = 8'h00;
      1: v = 8'h7F;
      2: v = 8'h80;
      3: v = 8'hFF;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.a = rnd8();
    o.b = rnd8();
    o.s = 1'($urandom_range(0, 1));
    return o;
  endfunction

  // Requester drivers: hold valid while an op is pending, advance on handshake.
  initial begin
    r0_if.valid = 1'b0; r0_if.a = 8'h00; r0_if.b = 8'h00; r0_if.sign = 1'b0;
    r1_if.valid = 1'b0; r1_if.a = 8'h00; r1_if.b = 8'h00; r1_if.sign = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      r0_if.valid = (q0.size() > 0);
      if (q0.size() > 0) begin
        r0_if.a = q0[0].a; r0_if.b = q0[0].b; r0_if.sign = q0[0].s;
      end else begin
        r0_if.a = 8'($urandom); r0_if.b = 8'($urandom); r0_if.sign = 1'($urandom);
      end
      r1_if.valid = (q1.size() > 0);
      if (q1.size() > 0) begin
        r1_if.a = q1[0].a; r1_if.b = q1[0].b; r1_if.sign = q1[0].s;
      end else begin
        r1_if.a = 8'($urandom); r1_if.b = 8'($urandom); r1_if.sign = 1'($urandom);
      end
    end
  end

  // Reference model: an accepted op is presented from two cycles after its
  // accept cycle until taken; the window opens when nothing is outstanding or
  // the presented result is being taken.
  initial begin
    forever begin
      @(negedge clk);
      acc0 = r0_if.valid && r0_if.ready;
      acc1 = r1_if.valid && r1_if.ready;
      if (!rst_n) begin
        chk("rst_req0_ready", r0_if.ready, 1'b0);
        chk("rst_req1_ready", r1_if.ready, 1'b0);
        chk("rst_out_valid", o_if.valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        have_op = 1'b0;
        lg_m    = 1'b1;
        sb.delete();
      end else begin
        bit v0, v1, pres, win, g, e0, e1;
        v0   = r0_if.valid;
        v1   = r1_if.valid;
        pres = have_op && (cyc >= op_cyc + 2);
        win  = !have_op || (pres && o_if.ready);
        g    = (v0 && v1) ? !lg_m : v1;
        e0   = win && v0 && !g;
        e1   = win && v1 && g;
        chk("req0_ready", r0_if.ready, e0);
        chk("req1_ready", r1_if.ready, e1);
        chk("out_valid", o_if.valid, pres);
        chk("busy", busy, have_op);
        if (pres && o_if.ready) have_op = 1'b0;
        if (win && (v0 || v1)) begin
          res_t r;
          if (g) r.prod = ref_mul(r1_if.a, r1_if.b, r1_if.sign);
          else   r.prod = ref_mul(r0_if.a, r0_if.b, r0_if.sign);
          r.id = g;
          sb.push_back(r);
          have_op = 1'b1;
          op_cyc  = cyc;
          lg_m    = g;
        end
      end
      cyc++;
    end
  end

  // Output monitor: compare presented product against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && o_if.valid) begin
        if (sb.size() == 0) begin
          chk("out_unexpected", 1'b1, 1'b0);
        end else begin
          chk("out_prod", o_if.prod, sb[0].prod);
          chk("out_id", o_if.id, sb[0].id);
          if (o_if.ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || have_op || sb.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", (n >= budget), 1'b0);
    tick();
  endtask

  task automatic do_reset(input int hold);
    tick();
    #1 rst_n = 1'b0;
    repeat (hold) tick();
    #1 rst_n = 1'b1;
  endtask

  task automatic reset_mid(input bit in_done);
    int n = 0;
    o_if.ready = !in_done;
    q0.push_back('{a: 8'h11, b: 8'h22, s: 1'b0});
    q0.push_back('{a: 8'hF0, b: 8'h03, s: 1'b1});
    while (!have_op && n < 20) begin
      tick();
      n++;
    end
    chk("mid_accept_timeout", (n >= 20), 1'b0);
    if (in_done) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", o_if.valid, 1'b0);
    chk("async_busy", busy, 1'b0);
    repeat (2) tick();
    #1 rst_n = 1'b1;
    o_if.ready = 1'b1;
    wait_idle(40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    o_if.ready = 1'b0;
    repeat (3) tick();
    #1 rst_n = 1'b1;
    #1;
    chk("reset_out_prod", o_if.prod, 16'h0000);
    chk("reset_out_id", o_if.id, 1'b0);
    chk("reset_out_valid", o_if.valid, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // Signed and unsigned single operations.
    o_if.ready = 1'b1;
    q0.push_back('{a: 8'hFD, b: 8'h05, s: 1'b1});
    wait_idle(20);
    q1.push_back('{a: 8'hC8, b: 8'hC8, s: 1'b0});
    wait_idle(20);

    // Tie straight after reset: req0 wins first, then alternation.
    do_reset(2);
    q0.push_back('{a: 8'h02, b: 8'h03, s: 1'b0});
    q0.push_back('{a: 8'h07, b: 8'hF9, s: 1'b1});
    q0.push_back('{a: 8'h80, b: 8'h01, s: 1'b1});
    q1.push_back('{a: 8'h04, b: 8'h05, s: 1'b0});
    q1.push_back('{a: 8'hFF, b: 8'hFF, s: 1'b1});
    q1.push_back('{a: 8'hFF, b: 8'hFF, s: 1'b0});
    wait_idle(40);

    // Backpressure with both requesters waiting.
    o_if.ready = 1'b0;
    q0.push_back('{a: 8'h9A, b: 8'h3C, s: 1'b1});
    q1.push_back('{a: 8'h12, b: 8'h34, s: 1'b0});
    n = 0;
    while (!o_if.valid && n < 10) begin
      tick();
      n++;
    end
    chk("bp_valid_timeout", (n >= 10), 1'b0);
    repeat (5) tick();
    o_if.ready = 1'b1;
    wait_idle(40);

    // Back-to-back from req0 with the consumer always ready.
    o_if.ready = 1'b1;
    q0.push_back('{a: 8'h80, b: 8'h80, s: 1'b1});
    q0.push_back('{a: 8'h80, b: 8'h7F, s: 1'b1});
    q0.push_back('{a: 8'hFF, b: 8'hFF, s: 1'b0});
    q0.push_back('{a: 8'h80, b: 8'h80, s: 1'b0});
    q0.push_back('{a: 8'h00, b: 8'hFF, s: 1'b1});
    q0.push_back('{a: 8'h7F, b: 8'h7F, s: 1'b1});
    wait_idle(40);

    // Randomized traffic with random consumer stalls.
    repeat (400) begin
      tick();
      o_if.ready = ($urandom_range(0, 3) != 0);
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rnd_op());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rnd_op());
    end
    o_if.ready = 1'b1;
    wait_idle(60);

    // Reset during MUL, then during DONE under backpressure.
    reset_mid(1'b0);
    reset_mid(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
